// File: rtl/i2c_target.sv
// I2C target with a byte-addressed register file (pointer byte, then data).
// Ports: clk_i/rst_n_i, scl_i/sda_i in, sda_oe_o/busy_o/wr_stb_o out, dbg read.
module i2c_target #(
  parameter logic [6:0] SLV_ADDR  = 7'h50,
  parameter int         MEM_DEPTH = 16,
  parameter int         PTR_W     = $clog2(MEM_DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe_o,
  output logic             busy_o,
  output logic             wr_stb_o,
  input  logic [PTR_W-1:0] dbg_addr_i,
  output logic [7:0]       dbg_data_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_AACK, S_PTR, S_WDATA,
    S_WACK, S_RDATA, S_RACK, S_IGNORE
  } state_t;

  state_t           state;
  logic [7:0]       mem [MEM_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_inc;
  logic [7:0]       sh;
  logic [7:0]       sh_nx;
  logic [3:0]       cnt;

  logic scl_m, scl_s, scl_q;
  logic sda_m, sda_s, sda_q;
  logic scl_rise, scl_fall;
  logic start_c, stop_c;

  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  // SCL must be high on both samples so a data change never looks like START/STOP
  assign start_c  = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_c   = scl_s & scl_q & ~sda_q & sda_s;

  assign sh_nx      = {sh[6:0], sda_s};
  assign ptr_inc    = ptr + 1'b1;
  assign dbg_data_o = mem[dbg_addr_i];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      scl_m    <= 1'b1;
      scl_s    <= 1'b1;
      scl_q    <= 1'b1;
      sda_m    <= 1'b1;
      sda_s    <= 1'b1;
      sda_q    <= 1'b1;
      state    <= S_IDLE;
      ptr      <= '0;
      sh       <= '0;
      cnt      <= '0;
      sda_oe_o <= 1'b0;
      busy_o   <= 1'b0;
      wr_stb_o <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      scl_m    <= scl_i;
      scl_s    <= scl_m;
      scl_q    <= scl_s;
      sda_m    <= sda_i;
      sda_s    <= sda_m;
      sda_q    <= sda_s;
      wr_stb_o <= 1'b0;
      if (start_c) begin
        state    <= S_ADDR;
        cnt      <= '0;
        sda_oe_o <= 1'b0;
      end else if (stop_c) begin
        state    <= S_IDLE;
        busy_o   <= 1'b0;
        sda_oe_o <= 1'b0;
      end else begin
        unique case (state)
          S_ADDR, S_PTR, S_WDATA: begin
            if (scl_rise) begin
              sh  <= sh_nx;
              cnt <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                if (state == S_ADDR) begin
                  if (sh_nx[7:1] == SLV_ADDR) begin
                    busy_o <= 1'b1;
                    state  <= S_AACK;
                  end else begin
                    state <= S_IGNORE;
                  end
                end else begin
                  if (state == S_PTR) begin
                    ptr <= sh_nx[PTR_W-1:0];
                  end else begin
                    mem[ptr] <= sh_nx;
                    wr_stb_o <= 1'b1;
                    ptr      <= ptr_inc;
                  end
                  state <= S_WACK;
                end
              end
            end
          end
          // First fall after bit 8 starts the ACK, the second one ends it.
          S_AACK, S_WACK: begin
            if (scl_fall) begin
              if (!sda_oe_o) begin
                sda_oe_o <= 1'b1;
              end else begin
                sda_oe_o <= 1'b0;
                cnt      <= '0;
                if (state == S_WACK) begin
                  state <= S_WDATA;
                end else if (!sh[0]) begin
                  state <= S_PTR;
                end else begin
                  // first read bit goes out on this same fall
                  sda_oe_o <= ~mem[ptr][7];
                  sh       <= {mem[ptr][6:0], 1'b0};
                  cnt      <= 4'd1;
                  state    <= S_RDATA;
                end
              end
            end
          end
          S_RDATA: begin
            if (scl_fall) begin
              if (cnt == 4'd8) begin
                sda_oe_o <= 1'b0;
                state    <= S_RACK;
              end else begin
                sda_oe_o <= ~sh[7];
                sh       <= {sh[6:0], 1'b0};
                cnt      <= cnt + 4'd1;
              end
            end
          end
          // pointer advances past the byte just sent, on ACK or NACK
          S_RACK: begin
            if (scl_rise) begin
              ptr <= ptr_inc;
              if (!sda_s) begin
                sh    <= mem[ptr_inc];
                cnt   <= '0;
                state <= S_RDATA;
              end else begin
                state <= S_IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bus-master tasks, register-file model, random traffic.
// Checks ACKs, read data, strobes, busy, SDA release and reset behaviour.
module tb_i2c_target;

  localparam int Q = 5;
  localparam int H = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic       busy;
  logic       wr_stb;
  logic [3:0] dbg_addr = '0;
  logic [7:0] dbg_data;

  int n_chk = 0;
  int n_pass = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;
  int stb_cnt = 0;
  int mptr = 0;

  logic [7:0] model [16];
  logic [7:0] wbuf [4];

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target #(
    .SLV_ADDR (7'h50),
    .MEM_DEPTH(16)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .scl_i     (scl_m),
    .sda_i     (sda_bus),
    .sda_oe_o  (sda_oe),
    .busy_o    (busy),
    .wr_stb_o  (wr_stb),
    .dbg_addr_i(dbg_addr),
    .dbg_data_o(dbg_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    oe_cnt   <= oe_cnt + (sda_oe ? 1 : 0);
    busy_cnt <= busy_cnt + (busy ? 1 : 0);
    stb_cnt  <= stb_cnt + (wr_stb ? 1 : 0);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wt(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mem_chk(input string tag, input int a, input logic [7:0] e);
    dbg_addr = a[3:0];
    #1;
    check(tag, dbg_data, e);
  endtask

  task automatic start_c();
    sda_m = 1'b1; wt(Q);
    scl_m = 1'b1; wt(Q);
    sda_m = 1'b0; wt(Q);
    scl_m = 1'b0; wt(Q);
  endtask

  task automatic stop_c();
    sda_m = 1'b0; wt(Q);
    scl_m = 1'b1; wt(Q);
    sda_m = 1'b1; wt(Q);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wt(Q);
      scl_m = 1'b1; wt(H);
      scl_m = 1'b0; wt(Q);
    end
  endtask

  task automatic get_ack(output logic a);
    sda_m = 1'b1; wt(Q);
    scl_m = 1'b1; wt(Q);
    a = sda_bus;  wt(Q);
    scl_m = 1'b0; wt(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    send_bits(b);
    get_ack(a);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wt(Q);
      scl_m = 1'b1; wt(Q);
      b[i] = sda_bus; wt(Q);
      scl_m = 1'b0; wt(Q);
    end
    sda_m = nack; wt(Q);
    scl_m = 1'b1; wt(H);
    scl_m = 1'b0; wt(Q);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    mptr = 0;
  endtask

  task automatic do_write(input logic [7:0] p, input int n);
    logic a;
    start_c();
    send_byte(8'hA0, a);
    check("wr_addr_ack", a, 0);
    check("busy_on", busy, 1);
    send_byte(p, a);
    check("wr_ptr_ack", a, 0);
    mptr = p % 16;
    for (int k = 0; k < n; k++) begin
      send_byte(wbuf[k], a);
      check("wr_data_ack", a, 0);
      model[mptr] = wbuf[k];
      mptr = (mptr + 1) % 16;
    end
    stop_c();
    check("busy_off", busy, 0);
  endtask

  task automatic do_read(input logic [7:0] p, input int n);
    logic       a;
    logic [7:0] b;
    int         snap;
    start_c();
    send_byte(8'hA0, a);
    check("rd_addr_ack", a, 0);
    send_byte(p, a);
    check("rd_ptr_ack", a, 0);
    start_c();
    send_byte(8'hA1, a);
    check("rd_raddr_ack", a, 0);
    mptr = p % 16;
    for (int k = 0; k < n; k++) begin
      recv_byte(k == n - 1, b);
      check("rd_data", b, model[mptr]);
      mptr = (mptr + 1) % 16;
    end
    snap = oe_cnt;
    stop_c();
    wt(2 * H);
    check("post_nack_release", oe_cnt, snap);
  endtask

  initial begin
    logic       a;
    int         snap_oe;
    int         snap_busy;
    int         snap_stb;
    logic [7:0] v;

    clear_model();
    rst_n = 1'b0;
    wt(4);
    check("rst_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_stb", wr_stb, 0);
    for (int i = 0; i < 16; i++) mem_chk("rst_mem", i, 8'h00);
    rst_n = 1'b1;
    wt(4);

    // write 0x11, 0x22 at pointer 3, read them back
    snap_stb = stb_cnt;
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    do_write(8'h03, 2);
    check("wr_stb_pulses", stb_cnt - snap_stb, 2);
    mem_chk("mem3", 3, 8'h11);
    mem_chk("mem4", 4, 8'h22);
    do_read(8'h03, 2);

    // foreign address: no ACK, no busy, no write
    snap_oe   = oe_cnt;
    snap_busy = busy_cnt;
    start_c();
    send_byte(8'hA4, a);
    check("nomatch_addr_nack", a, 1);
    send_byte(8'h00, a);
    check("nomatch_b1_nack", a, 1);
    send_byte(8'h55, a);
    check("nomatch_b2_nack", a, 1);
    stop_c();
    check("nomatch_oe", oe_cnt - snap_oe, 0);
    check("nomatch_busy", busy_cnt - snap_busy, 0);
    mem_chk("nomatch_mem0", 0, model[0]);

    // pointer wrap
    wbuf[0] = 8'hAA;
    wbuf[1] = 8'hBB;
    do_write(8'h0F, 2);
    mem_chk("wrap_mem15", 15, 8'hAA);
    mem_chk("wrap_mem0", 0, 8'hBB);
    do_read(8'h0F, 2);

    // combined format single byte
    wbuf[0] = 8'($urandom_range(0, 255));
    do_write(8'h05, 1);
    do_read(8'h05, 1);

    // pointer byte masked to 4 bits
    wbuf[0] = 8'($urandom_range(0, 255));
    do_write(8'h13, 1);
    mem_chk("mask_mem3", 3, wbuf[0]);

    // random traffic
    for (int t = 0; t < 20; t++) begin
      v = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 4; k++) wbuf[k] = 8'($urandom_range(0, 255));
        do_write(v, $urandom_range(1, 4));
      end else begin
        do_read(v, $urandom_range(1, 3));
      end
    end
    for (int i = 0; i < 16; i++) mem_chk("scan_mem", i, model[i]);

    // reset while the target drives the address ACK
    start_c();
    send_bits(8'hA0);
    sda_m = 1'b1;
    wt(Q);
    check("midack_oe", sda_oe, 1);
    rst_n = 1'b0;
    wt(1);
    check("midrst_oe", sda_oe, 0);
    check("midrst_busy", busy, 0);
    clear_model();
    for (int i = 0; i < 16; i++) mem_chk("midrst_mem", i, 8'h00);
    wt(2);
    rst_n = 1'b1;
    snap_oe = oe_cnt;
    scl_m = 1'b1; wt(H);
    scl_m = 1'b0; wt(Q);
    stop_c();
    check("midrst_ignore_oe", oe_cnt - snap_oe, 0);
    for (int k = 0; k < 4; k++) wbuf[k] = 8'($urandom_range(0, 255));
    do_write(8'($urandom_range(0, 15)), 3);
    for (int i = 0; i < 16; i++) mem_chk("post_rst_mem", i, model[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- Synthesizable I2C target (slave) that sits on the far end of the bus from the APB4 I2C controller. Used as the bus partner in block-level benches and as the target for on-chip register-access peripherals.
- Implements a byte-addressed register file. Protocol:
  - Write: 7-bit address + W, one pointer byte, then data bytes.
  - Read: 7-bit address + R, data bytes streamed from the pointer.
- Oversamples SCL/SDA on the system clock. SCL stretching is not supported.

Parameters:
- SLV_ADDR, 7'h50, 7-bit target address matched against the first byte after START.
- MEM_DEPTH, 16, number of 8-bit registers; power of two, 2..256.
- PTR_W, $clog2(MEM_DEPTH), pointer width (derived).

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_n_i  in  1  synchronous active-low reset.
- scl_i  in  1  SCL line input (asynchronous to clk_i).
- sda_i  in  1  SDA line input (asynchronous to clk_i).
- sda_oe_o  out  1  1 = pull SDA low (open drain); the pad drives 0 when set, otherwise Z.
- busy_o  out  1  high from an address-matched START until STOP.
- wr_stb_o  out  1  one-cycle pulse when a data byte is committed to memory.
- dbg_addr_i  in  PTR_W  debug read address.
- dbg_data_o  out  8  mem[dbg_addr_i], combinational read.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rst_n_i.
- Reset values:
  - sda_oe_o=0, busy_o=0, wr_stb_o=0.
  - State=IDLE, pointer=0, shift register=0, bit counter=0, all mem entries=8'h00.
  - Synchronizers preset to 1.
- Reset asserted mid-transfer: sda_oe_o releases on the next clock edge; the target then ignores the bus until the next START.
- Input sampling:
  - scl_i and sda_i each pass through a 2-FF synchronizer followed by a previous-value register.
  - Edges are detected 2-3 clk after the line changes.
  - Requirement on the bus: SCL high and low phases each >= 4 clk_i periods.
- Bus conditions:
  - START/Sr: synced SDA falls while synced SCL is high. From any state go to ADDR, clear the bit counter, release sda_oe_o.
  - STOP: synced SDA rises while synced SCL is high. From any state go to IDLE, busy_o=0, release sda_oe_o.
  - START and STOP take priority over bit sampling in the same cycle.
- Bit timing:
  - Receive: sample on the SCL rising edge, MSB first.
  - Transmit: change the driven bit on the SCL falling edge.
  - The bit counter runs 0..8; count 8 is the ACK slot.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - Upper 7 bits == SLV_ADDR: busy_o=1 and go to ADDR_ACK.
    - Otherwise: go to IGNORE, with no ACK driven.
  - ADDR_ACK: drive sda_oe_o=1 from the SCL fall after bit 8 until the next SCL fall. Then:
    - R/W=0: go to PTR.
    - R/W=1: load tx = mem[pointer] and go to RDATA.
  - PTR: shift 8 bits, then pointer = byte[PTR_W-1:0] (upper bits dropped), then ACK and go to WDATA.
  - WDATA: shift 8 bits, then on the ACK phase:
    - mem[pointer] = byte, with a wr_stb_o pulse on the commit cycle.
    - pointer = pointer+1 mod MEM_DEPTH.
    - ACK is driven, then stay in WDATA.
  - RDATA:
    - On each SCL fall, sda_oe_o = ~tx[7-bit].
    - After the 8th bit, release SDA and go to RACK.
  - RACK: sample the master's bit on the SCL rise.
    - 0 (ACK): pointer++ mod MEM_DEPTH, load the next byte, go to RDATA.
    - 1 (NACK): go to IGNORE; pointer stays pointing at the byte after the last one sent.
  - IGNORE: never drive SDA; wait for STOP or Sr.
- Pointer persistence: the pointer persists across transactions and is not cleared at STOP. A write of only the pointer byte followed by Sr + R reads from that pointer.
- Simultaneous debug read and bus write to the same entry: dbg_data_o shows the old value until the cycle after the commit.

Test Plan:
- Write then read back: START, 0xA0, 0x03, 0x11, 0x22, STOP; then START, 0xA1, read 2 bytes with ACK then NACK, STOP.
  - Required: ACK on all 4 written bytes; mem[3]=0x11 and mem[4]=0x22; two wr_stb_o pulses; read returns 0x11 then 0x22.
- Address mismatch: START, 0xA4, 0x00, 0x55, STOP.
  - Required: sda_oe_o stays 0 throughout, busy_o stays 0, mem unchanged.
- Pointer wrap: write pointer 0x0F, data 0xAA then 0xBB.
  - Required: mem[15]=0xAA, mem[0]=0xBB.
  - Follow with a read from pointer 0x0F of 2 bytes: returns 0xAA, 0xBB.
- Combined format: START, 0xA0, 0x05, Sr, 0xA1, read 1 byte with NACK, STOP.
  - Required: returns mem[5]; after the NACK, SDA is never driven low.
- Pointer-byte masking: write pointer 0x13 with MEM_DEPTH=16.
  - Required: the write lands at mem[3].
- Reset mid-transfer: assert rst_n_i while the target is driving ACK.
  - Required: sda_oe_o=0 on the next clk edge, all mem=0, busy_o=0.
  - A subsequent full write transaction succeeds.
